// File: rtl/pc_fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM state encoding, machine word, reset PC.
package pc_fetch_pkg;

   typedef logic [15:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam word_t RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/pc_fetch_reg_16.sv
// 16-bit register with synchronous active-low reset and load enable; used for PC, MAR and IR.
module reg_16
   import pc_fetch_pkg::*;
#(
   parameter word_t RST_VAL = 16'h0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ld,
   input  logic [15:0] i_d,
   output logic [15:0] o_q
);

   logic [15:0] r_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_q <= RST_VAL;
      end else if (i_ld) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pc_fetch.sv
// Program counter plus single-outstanding instruction fetch FSM.
// Define PC_FETCH_TIMEOUT_EN to build the WAIT-state timeout counter and fetch_err pulse.
//
// state | meaning
// IDLE  | no fetch in flight, IR empty
// REQ   | first cycle of memory read request, MAR valid
// WAIT  | read request held until mem_ready (or timeout)
// HOLD  | IR holds an unconsumed instruction
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter word_t RESET_PC       = RESET_PC_DEFAULT,
   parameter int    TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_ld_pc,
   input  logic [15:0] i_pc_next,
   output logic [15:0] o_pc,
   output logic [15:0] o_pc_plus1,
   input  logic        i_fetch_start,
   output logic        o_mem_req,
   output logic [15:0] o_mem_addr,
   input  logic [15:0] i_mem_rdata,
   input  logic        i_mem_ready,
   output logic [15:0] o_ir,
   output logic        o_ir_valid,
   input  logic        i_ir_ack,
   output logic        o_busy,
   output logic        o_fetch_err
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic         w_mar_ld;
   logic         w_ir_ld;
   logic         w_timeout;
   logic [15:0]  w_pc;
   logic [15:0]  w_mar;
   logic [15:0]  w_ir;

   reg_16 #(.RST_VAL(RESET_PC)) u_pc (
      .i_clk   (i_clk),
      .i_rst_n (i_reset_n),
      .i_ld    (i_ld_pc),
      .i_d     (i_pc_next),
      .o_q     (w_pc)
   );

   // MAR samples the register output, so a same-cycle LD_PC still fetches the old PC.
   reg_16 #(.RST_VAL(16'h0000)) u_mar (
      .i_clk   (i_clk),
      .i_rst_n (i_reset_n),
      .i_ld    (w_mar_ld),
      .i_d     (w_pc),
      .o_q     (w_mar)
   );

   reg_16 #(.RST_VAL(16'h0000)) u_ir (
      .i_clk   (i_clk),
      .i_rst_n (i_reset_n),
      .i_ld    (w_ir_ld),
      .i_d     (i_mem_rdata),
      .o_q     (w_ir)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_mar_ld    = 1'b0;
      w_ir_ld     = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_fetch_start) begin
               w_mar_ld    = 1'b1;
               w_state_nxt = REQ;
            end
         end
         REQ, WAIT: begin
            if (i_mem_ready) begin
               w_ir_ld     = 1'b1;
               w_state_nxt = HOLD;
            end else if (w_timeout) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = WAIT;
            end
         end
         HOLD: begin
            if (i_ir_ack) begin
               if (i_fetch_start) begin
                  w_mar_ld    = 1'b1;
                  w_state_nxt = REQ;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

`ifdef PC_FETCH_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

   logic [7:0] r_to_cnt;
   logic       r_fetch_err;

   assign w_timeout = (r_state == WAIT) && !i_mem_ready && (r_to_cnt == TO_LIM);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_to_cnt    <= 8'd0;
         r_fetch_err <= 1'b0;
      end else begin
         r_fetch_err <= w_timeout;
         if (w_mar_ld) begin
            r_to_cnt <= 8'd0;
         end else if (r_state == WAIT) begin
            r_to_cnt <= r_to_cnt + 8'd1;
         end
      end
   end

   assign o_fetch_err = r_fetch_err;
`else
   assign w_timeout   = 1'b0;
   assign o_fetch_err = 1'b0;
`endif

   assign o_pc       = w_pc;
   assign o_pc_plus1 = w_pc + 16'd1;
   assign o_mem_addr = w_mar;
   assign o_mem_req  = (r_state == REQ) || (r_state == WAIT);
   assign o_ir       = w_ir;
   assign o_ir_valid = (r_state == HOLD);
   assign o_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios followed by random traffic against a
// transaction-level reference model (pending request / held instruction / request age).
module tb_pc_fetch;

   localparam int          TO  = 4;
   localparam logic [15:0] RPC = 16'h0000;

   logic        clk;
   logic        rst_n;
   logic        ld_pc;
   logic [15:0] pc_next;
   logic [15:0] pc;
   logic [15:0] pc_plus1;
   logic        fetch_start;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic [15:0] ir;
   logic        ir_valid;
   logic        ir_ack;
   logic        busy;
   logic        fetch_err;

   pc_fetch #(.RESET_PC(RPC), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_ld_pc       (ld_pc),
      .i_pc_next     (pc_next),
      .o_pc          (pc),
      .o_pc_plus1    (pc_plus1),
      .i_fetch_start (fetch_start),
      .o_mem_req     (mem_req),
      .o_mem_addr    (mem_addr),
      .i_mem_rdata   (mem_rdata),
      .i_mem_ready   (mem_ready),
      .o_ir          (ir),
      .o_ir_valid    (ir_valid),
      .i_ir_ack      (ir_ack),
      .o_busy        (busy),
      .o_fetch_err   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: a fetch is either pending at memory, held for the decoder, or absent
   logic [15:0] m_pc    = RPC;
   logic [15:0] m_mar   = 16'h0000;
   logic [15:0] m_ir    = 16'h0000;
   logic        m_pend  = 1'b0;
   logic        m_valid = 1'b0;
   logic        m_err   = 1'b0;
   int          m_age   = 0;

   task automatic chk16(string tag, logic [15:0] obs, logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic [15:0] old_pc;
      old_pc = m_pc;
      if (!rst_n) begin
         m_pc = RPC; m_mar = 16'h0000; m_ir = 16'h0000;
         m_pend = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_age = 0;
      end else begin
         m_err = 1'b0;
         if (m_pend) begin
            if (mem_ready) begin
               m_ir = mem_rdata; m_valid = 1'b1; m_pend = 1'b0;
            end
`ifdef PC_FETCH_TIMEOUT_EN
            else if (m_age == TO + 1) begin
               m_pend = 1'b0; m_err = 1'b1;
            end
`endif
            else begin
               m_age++;
            end
         end else if (m_valid) begin
            if (ir_ack) begin
               m_valid = 1'b0;
               if (fetch_start) begin
                  m_mar = old_pc; m_pend = 1'b1; m_age = 0;
               end
            end
         end else if (fetch_start) begin
            m_mar = old_pc; m_pend = 1'b1; m_age = 0;
         end
         if (ld_pc) m_pc = pc_next;
      end
   endtask

   task automatic check_all();
      chk16("pc", pc, m_pc);
      chk16("pc_plus1", pc_plus1, m_pc + 16'd1);
      chk1("mem_req", mem_req, m_pend);
      chk16("mem_addr", mem_addr, m_mar);
      chk16("ir", ir, m_ir);
      chk1("ir_valid", ir_valid, m_valid);
      chk1("busy", busy, m_pend | m_valid);
      chk1("fetch_err", fetch_err, m_err);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic drive(logic r, logic ld, logic [15:0] pn, logic fs,
                        logic rdy, logic [15:0] rd, logic ack);
      rst_n = r; ld_pc = ld; pc_next = pn; fetch_start = fs;
      mem_ready = rdy; mem_rdata = rd; ir_ack = ack;
   endtask

   initial begin
      int n_req;
      int n_err;
      int n_busy;
      logic [15:0] addr0;

      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
      #1;
      cycle();
      cycle();
      chk16("rst_pc", pc, RPC);
      chk1("rst_busy", busy, 1'b0);

      // reset then minimum-latency fetch
      drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      cycle();
      chk1("t038_req", mem_req, 1'b1);
      chk16("t038_addr", mem_addr, 16'h0000);
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1234, 1'b0);
      cycle();
      chk1("t038_valid", ir_valid, 1'b1);
      chk16("t038_ir", ir, 16'h1234);
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
      cycle();
      chk1("t038_ack", ir_valid, 1'b0);

      // wait states: ready delayed by three cycles
      drive(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 1'b0);
      cycle();
      drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      cycle();
      n_req = mem_req ? 1 : 0;
      addr0 = mem_addr;
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (mem_req) n_req++;
         chk16("t039_addr", mem_addr, 16'h0040);
         chk1("t039_novalid", ir_valid, 1'b0);
      end
      chk16("t039_nreq", 16'(n_req), 16'd4);
      chk16("t039_addr0", addr0, 16'h0040);
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h5A5A, 1'b0);
      cycle();
      chk1("t039_valid", ir_valid, 1'b1);
      chk1("t039_reqoff", mem_req, 1'b0);
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
      cycle();
      chk1("t039_once", ir_valid, 1'b0);

      // PC wrap through the pc_plus1 path
      drive(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0, 1'b0);
      cycle();
      chk16("t040_plus1", pc_plus1, 16'h0000);
      drive(1'b1, 1'b1, pc_plus1, 1'b0, 1'b0, 16'h0, 1'b0);
      cycle();
      chk16("t040_pc", pc, 16'h0000);

      // back-to-back fetch from HOLD, then LD_PC with fetch_start in IDLE
      drive(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 1'b0);
      cycle();
      drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      cycle();
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'hC0DE, 1'b0);
      cycle();
      drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);
      cycle();
      chk1("t041_req", mem_req, 1'b1);
      chk1("t041_busy", busy, 1'b1);
      chk16("t041_addr", mem_addr, 16'h0010);
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'hBEEF, 1'b0);
      cycle();
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
      cycle();
      drive(1'b1, 1'b1, 16'h2222, 1'b1, 1'b0, 16'h0, 1'b0);
      cycle();
      chk16("t041_oldpc", mem_addr, 16'h0010);
      chk16("t041_newpc", pc, 16'h2222);

      // reset in WAIT; late ready must be ignored
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
      cycle();
      drive(1'b0, 1'b1, 16'h7777, 1'b1, 1'b1, 16'h9999, 1'b0);
      cycle();
      chk1("t042_req", mem_req, 1'b0);
      chk1("t042_busy", busy, 1'b0);
      chk16("t042_pc", pc, RPC);
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h9999, 1'b0);
      cycle();
      chk1("t042_late", ir_valid, 1'b0);
      chk16("t042_ir", ir, 16'h0000);

      // memory never answers
      drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
      cycle();
      drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'hDEAD, 1'b0);
      n_err  = 0;
      n_busy = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (fetch_err) n_err++;
         if (busy) n_busy++;
      end
`ifdef PC_FETCH_TIMEOUT_EN
      chk16("t043_errcnt", 16'(n_err), 16'd1);
      chk16("t043_busycnt", 16'(n_busy), 16'(TO + 1));
      chk1("t043_idle", busy, 1'b0);
`else
      chk16("t043_errcnt", 16'(n_err), 16'd0);
      chk16("t043_busycnt", 16'(n_busy), 16'd12);
      chk1("t043_busy", busy, 1'b1);
`endif
      chk1("t043_valid", ir_valid, 1'b0);
      chk16("t043_ir", ir, 16'h0000);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(63) != 0),
               ($urandom_range(4) == 0),
               16'($urandom),
               ($urandom_range(1) == 1),
               ($urandom_range(9) < 4),
               16'($urandom),
               ($urandom_range(1) == 1));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the value loaded into PC on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL be the WAIT-cycle limit used when the timeout feature is compiled in.
REQ-003 Clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Reset_n  input  1  reset; synchronous, active-low.
REQ-005 LD_PC  input  1  load enable for PC from pc_next.
REQ-006 pc_next  input  16  next-PC value, sourced from the PC select mux output.
REQ-007 PC  output  16  current program counter.
REQ-008 pc_plus1  output  16  PC+1, feeds the PC select mux sequential input.
REQ-009 fetch_start  input  1  request to fetch the instruction at PC.
REQ-010 mem_req  output  1  memory read request.
REQ-011 mem_addr  output  16  memory read address.
REQ-012 mem_rdata  input  16  memory read data, valid when mem_ready=1.
REQ-013 mem_ready  input  1  memory read completion.
REQ-014 IR  output  16  fetched instruction.
REQ-015 ir_valid  output  1  IR holds an unconsumed instruction.
REQ-016 ir_ack  input  1  decoder consumes IR.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 fetch_err  output  1  one-cycle pulse on fetch timeout.

Function
REQ-019 pc_plus1 SHALL equal PC+1 combinationally, modulo 2^16; PC=16'hFFFF gives pc_plus1=16'h0000.
REQ-020 PC SHALL load pc_next on the clock edge following LD_PC=1 in any state; otherwise PC SHALL hold.
REQ-021 The FSM SHALL have four states: IDLE, REQ, WAIT, HOLD.
REQ-022 In IDLE with fetch_start=1, the block SHALL latch PC into MAR and go to REQ; if LD_PC=1 in the same cycle, MAR SHALL take the old PC.
REQ-023 mem_addr SHALL equal MAR, and mem_req SHALL be 1 exactly in REQ and WAIT.
REQ-024 In REQ or WAIT with mem_ready=1, the block SHALL capture mem_rdata into IR and go to HOLD; with mem_ready=0, it SHALL go to (or stay in) WAIT.
REQ-025 ir_valid SHALL be 1 exactly in HOLD, and IR SHALL be stable throughout HOLD.
REQ-026 In HOLD with ir_ack=1 and fetch_start=0, the block SHALL go to IDLE; with ir_ack=1 and fetch_start=1, it SHALL latch PC into MAR and go to REQ (back-to-back fetch).
REQ-027 In HOLD with ir_ack=0, fetch_start SHALL be ignored; fetch_start SHALL also be ignored in REQ and WAIT.
REQ-028 ir_ack outside HOLD SHALL be ignored.
REQ-029 Minimum latency: fetch_start in cycle 0, with mem_ready=1 in cycle 1, SHALL give ir_valid=1 in cycle 2.
REQ-030 LD_PC during REQ, WAIT or HOLD SHALL update PC without affecting the fetch in flight.

Reset
REQ-031 Reset_n=0 SHALL take effect at the next rising edge, in any state including mid-fetch.
REQ-032 On reset: state=IDLE, PC=RESET_PC, MAR=0, IR=0, ir_valid=0, mem_req=0, busy=0, fetch_err=0, timeout counter=0.
REQ-033 Reset SHALL have priority over LD_PC, fetch_start and mem_ready.

Configuration
REQ-034 With PC_FETCH_TIMEOUT_EN defined:
- an 8..16-bit counter SHALL clear on entry to REQ and increment each cycle in WAIT;
- when the counter reaches TIMEOUT_CYCLES with mem_ready=0, fetch_err SHALL pulse for 1 cycle, the FSM SHALL go to IDLE, and IR SHALL be unchanged.
REQ-035 Without PC_FETCH_TIMEOUT_EN:
- no counter SHALL be built;
- fetch_err SHALL be tied to 0;
- WAIT SHALL persist until mem_ready=1.

Structure
REQ-036 A shared package pc_fetch_pkg SHALL hold:
- the enum fetch_state_t {IDLE, REQ, WAIT, HOLD};
- the 16-bit word typedef;
- the default RESET_PC constant.
REQ-037 A sub-module reg_16 (16-bit register with sync active-low reset and load enable) SHALL be instantiated for PC, MAR and IR.

Verification
REQ-038 Reset then fetch: Reset_n=0 for 2 cycles, fetch_start=1, mem_ready=1 in first REQ cycle with mem_rdata=16'h1234 -> mem_addr=16'h0000, IR=16'h1234, ir_valid in cycle 2.
REQ-039 Wait states: mem_ready delayed 3 cycles -> mem_req held 4 cycles, mem_addr stable, ir_valid exactly once after ready.
REQ-040 PC wrap: LD_PC with pc_next=16'hFFFF -> pc_plus1=16'h0000; reload via pc_plus1 -> PC=16'h0000.
REQ-041 Simultaneous events: in HOLD, ir_ack=1 and fetch_start=1 with PC=16'h0010 -> next state REQ, mem_addr=16'h0010, no IDLE cycle. Separately, LD_PC=1 with fetch_start=1 in IDLE -> mem_addr=old PC.
REQ-042 Mid-fetch reset: Reset_n=0 during WAIT -> next cycle mem_req=0, busy=0, PC=RESET_PC, and a late mem_ready is ignored.
REQ-043 Timeout (macro on, TIMEOUT_CYCLES=4): mem_ready never asserted -> fetch_err single pulse, return to IDLE, ir_valid=0. With the macro off -> fetch_err stays 0 and busy stays 1.
